// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module      : la_pkg
// Description : Shared definitions for the logic-analyzer capture path.
//               Holds the controller state encoding, the config register
//               addresses, default sizing and the effective-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

  // Default sizing of the capture path
  localparam int LA_WIDTH   = 4;   // probe channels
  localparam int LA_DEPTH   = 16;  // sample buffer entries (power of two)
  localparam int LA_PRESC_W = 8;   // prescaler width

  // Controller state encoding (visible on the state output)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } la_state_t;

  // Config register addresses
  localparam logic [1:0] CFG_MASK  = 2'd0;
  localparam logic [1:0] CFG_PRESC = 2'd1;
  localparam logic [1:0] CFG_LEN   = 2'd2;

  // Effective capture length: a programmed length of zero, or one that does
  // not fit in the buffer, means "fill the whole buffer".
  function automatic int unsigned eff_len(input int unsigned length,
                                          input int unsigned depth);
    if ((length == 0) || (length > depth)) begin
      return depth;
    end
    return length;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sampler.sv
`default_nettype none
// ============================================================================
// Module      : shift_sampler
// Description : DEPTH-stage register chain on the raw probe inputs. Stage 0
//               is the input registered once, stage k is registered k+1
//               times. Also serves as the synchroniser for the pin inputs.
// Revision    : 1.0 - initial release
//
// Ports
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset, clears every stage
//   in_data in   WIDTH raw probe inputs
//   taps    out  DEPTH x WIDTH delayed copies of in_data
// ============================================================================
module shift_sampler #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_data,
  output logic [DEPTH-1:0][WIDTH-1:0]   taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : capture_controller
// Description : Logic-analyzer capture sequencer. Holds trigger mask,
//               prescaler and length configuration, arms on command, waits
//               for an edge on the masked channels, fills a flop-based sample
//               buffer every prescale+1 cycles and then drains it through a
//               request/valid read port.
// Revision    : 1.0 - initial release
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   WIDTH raw probe inputs
//   cfg_we     in   config write strobe (honoured in IDLE only)
//   cfg_addr   in   0 = trig_mask, 1 = prescale, 2 = length
//   cfg_wdata  in   config data, upper bits ignored
//   arm        in   single-cycle arm command
//   abort      in   single-cycle abort command (wins over arm)
//   rd_req     in   read one buffered sample (DONE only)
//   rd_valid   out  rd_data valid this cycle
//   rd_data    out  buffered sample
//   state      out  FSM state (IDLE/ARMED/CAPTURE/DONE)
//   trig_chan  out  channels that changed on the trigger cycle
// ============================================================================
module capture_controller
  import la_pkg::*;
#(
  parameter int WIDTH   = LA_WIDTH,
  parameter int DEPTH   = LA_DEPTH,
  parameter int PRESC_W = LA_PRESC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic             arm,
  input  logic             abort,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] trig_chan
);

  // Buffer index width and length width (length must be able to hold DEPTH)
  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;

  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [AW-1:0]      PTR_ONE   = AW'(1);

  // --------------------------------------------------------------------------
  // Input sampling: now = in_data registered once, prev = registered twice
  // --------------------------------------------------------------------------
  logic [1:0][WIDTH-1:0] taps;
  logic [WIDTH-1:0]      now_q;
  logic [WIDTH-1:0]      prev_q;
  logic [WIDTH-1:0]      edge_vec;

  shift_sampler #(
    .WIDTH (WIDTH),
    .DEPTH (2)
  ) u_sampler (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .taps    (taps)
  );

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  la_state_t            cur_state;
  la_state_t            next_state;

  logic [WIDTH-1:0]     trig_mask;
  logic [PRESC_W-1:0]   prescale;
  logic [LEN_W-1:0]     length_q;
  logic [LEN_W-1:0]     len;

  logic [PRESC_W-1:0]   presc_cnt;
  logic [LEN_W-1:0]     wr_cnt;
  logic [AW-1:0]        rd_ptr;
  logic [WIDTH-1:0]     sample_buf [DEPTH];

  // Decoded actions for the datapath, produced alongside next_state
  logic                 do_trigger;
  logic                 do_sample;
  logic                 capture_tick;
  logic                 do_read;
  logic                 read_last;
  logic                 arm_entry;

  assign now_q    = taps[0];
  assign prev_q   = taps[1];
  assign edge_vec = (now_q ^ prev_q) & trig_mask;

  assign len       = LEN_W'(eff_len(32'(length_q), 32'(DEPTH)));
  assign read_last = ({1'b0, rd_ptr} == (len - LEN_ONE));

  assign state = cur_state;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and action decode. abort overrides every other event,
  // including a same-cycle arm, sample or read.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state   = cur_state;
    do_trigger   = 1'b0;
    do_sample    = 1'b0;
    capture_tick = 1'b0;
    do_read      = 1'b0;
    arm_entry    = 1'b0;

    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (arm) begin
            next_state = ST_ARMED;
            arm_entry  = 1'b1;
          end
        end

        ST_ARMED: begin
          // With an all-zero mask no edge can ever qualify, so the capture
          // is forced immediately. Config is frozen while armed, so this
          // can only fire on the first ARMED cycle.
          if ((edge_vec != '0) || (trig_mask == '0)) begin
            do_trigger = 1'b1;
            next_state = (len == LEN_ONE) ? ST_DONE : ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          capture_tick = 1'b1;
          if (presc_cnt == prescale) begin
            do_sample = 1'b1;
            if ((wr_cnt + LEN_ONE) == len) begin
              next_state = ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (rd_req) begin
            do_read = 1'b1;
            if (read_last) begin
              next_state = ST_IDLE;
            end
          end
        end

        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Config, counters, sample buffer and read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_mask <= '1;
      prescale  <= '0;
      length_q  <= '0;
      presc_cnt <= '0;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      trig_chan <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sample_buf[i] <= '0;
      end
    end else begin
      rd_valid <= 1'b0;

      // Config is only writable while idle so a running capture cannot be
      // reshaped underneath itself.
      if (cfg_we && (cur_state == ST_IDLE)) begin
        case (cfg_addr)
          CFG_MASK:  trig_mask <= cfg_wdata[WIDTH-1:0];
          CFG_PRESC: prescale  <= cfg_wdata[PRESC_W-1:0];
          CFG_LEN:   length_q  <= cfg_wdata[LEN_W-1:0];
          default:   ;
        endcase
      end

      if (arm_entry) begin
        rd_ptr <= '0;
      end

      // The trigger cycle itself supplies sample 0
      if (do_trigger) begin
        sample_buf[0] <= now_q;
        trig_chan     <= edge_vec;
        wr_cnt        <= LEN_ONE;
        presc_cnt     <= '0;
      end

      if (do_sample) begin
        sample_buf[wr_cnt[AW-1:0]] <= now_q;
        wr_cnt                     <= wr_cnt + LEN_ONE;
        presc_cnt                  <= '0;
      end else if (capture_tick) begin
        presc_cnt <= presc_cnt + PRESC_ONE;
      end

      // The pointer parks on the last entry instead of running past len-1
      if (do_read) begin
        rd_valid <= 1'b1;
        rd_data  <= sample_buf[rd_ptr];
        if (!read_last) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_capture_controller
// Description : Directed self-checking bench for capture_controller. Each
//               task drives one scenario cycle by cycle and compares outputs
//               one time unit after the rising edge against hand-derived
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic [1:0] state;
  logic [3:0] trig_chan;

  int checks = 0;
  int errors = 0;

  capture_controller #(
    .WIDTH   (4),
    .DEPTH   (16),
    .PRESC_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .arm       (arm),
    .abort     (abort),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .state     (state),
    .trig_chan (trig_chan)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    settle(2);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (trig_chan !== 4'h0) begin errors++; $display("FAIL reset_trig_chan: got %h want 0", trig_chan); end
    rst_n = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic_capture();
    logic [3:0] exp_b [4];
    exp_b[0] = 4'h1; exp_b[1] = 4'h3; exp_b[2] = 4'h5; exp_b[3] = 4'h7;
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd1, 8'h00);
    cfg_write(2'd2, 8'h04);
    in_data = 4'h0;
    settle(2);
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_armed: got %0d want 1", state); end
    in_data = 4'h1; tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_edge_cycle: got %0d want 1", state); end
    in_data = 4'h3; tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_capture: got %0d want 2", state); end
    checks++; if (trig_chan !== 4'h1) begin errors++; $display("FAIL basic_trig_chan: got %h want 1", trig_chan); end
    in_data = 4'h5; tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_capture2: got %0d want 2", state); end
    in_data = 4'h7; tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_capture3: got %0d want 2", state); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_no_valid: got %0b want 0", rd_valid); end
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL basic_done: got %0d want 3", state); end
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin errors++; $display("FAIL basic_read%0d: got v=%0b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp_b[i]); end
      if (i == 2) begin
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL basic_still_done: got %0d want 3", state); end
      end
    end
    rd_req = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL basic_idle_after_read: got %0d want 0", state); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b want 0", rd_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_mask_filter();
    cfg_write(2'd0, 8'h02);
    in_data = 4'h0;
    settle(2);
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL mask_armed: got %0d want 1", state); end
    in_data = 4'h1;
    settle(3);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL mask_ch0_ignored: got %0d want 1", state); end
    in_data = 4'h3; tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL mask_ch1_edge_cycle: got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL mask_ch1_capture: got %0d want 2", state); end
    checks++; if (trig_chan !== 4'h2) begin errors++; $display("FAIL mask_trig_chan: got %h want 2", trig_chan); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mask_abort: got %0d want 0", state); end
    checks++; if (trig_chan !== 4'h2) begin errors++; $display("FAIL mask_trig_hold: got %h want 2", trig_chan); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_prescale_forced();
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'h03);
    cfg_write(2'd2, 8'h00);
    in_data = 4'h0;
    settle(2);
    // in_data carries j during the cycle before rising edge j+1
    in_data = 4'h1; arm = 1'b1; tick(); arm = 1'b0;
    in_data = 4'h2;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL presc_armed: got %0d want 1", state); end
    for (int j = 2; j <= 62; j++) begin
      tick();
      in_data = 4'((j + 1) & 15);
      if (j == 2) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL presc_forced_trigger: got %0d want 2", state); end
        checks++; if (trig_chan !== 4'h0) begin errors++; $display("FAIL presc_trig_chan: got %h want 0", trig_chan); end
      end
      if (j == 61) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL presc_not_done_early: got %0d want 2", state); end
      end
      if (j == 62) begin
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL presc_done: got %0d want 3", state); end
      end
    end
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 4'((1 + 4 * i) & 15)) begin errors++; $display("FAIL presc_read%0d: got v=%0b d=%h want v=1 d=%h", i, rd_valid, rd_data, 4'((1 + 4 * i) & 15)); end
    end
    rd_req = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL presc_idle: got %0d want 0", state); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_abort_arb();
    in_data = 4'h0;
    settle(2);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL arb_abort_wins: got %0d want 0", state); end
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd1, 8'h00);
    cfg_write(2'd2, 8'h02);
    arm = 1'b1; tick(); arm = 1'b0;
    // A zero mask or length 1 landing here would force a trigger / skip CAPTURE
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd2, 8'h01);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arb_cfg_locked_mask: got %0d want 1", state); end
    in_data = 4'h1; tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arb_edge_cycle: got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL arb_cfg_locked_len: got %0d want 2", state); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL arb_abort_capture: got %0d want 0", state); end
    checks++; if (trig_chan !== 4'h1) begin errors++; $display("FAIL arb_trig_hold: got %h want 1", trig_chan); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_boundaries();
    // length 1: falling edge on ch0 goes straight to DONE
    cfg_write(2'd2, 8'h01);
    settle(2);
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL len1_armed: got %0d want 1", state); end
    in_data = 4'h0; tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL len1_edge_cycle: got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL len1_direct_done: got %0d want 3", state); end
    checks++; if (trig_chan !== 4'h1) begin errors++; $display("FAIL len1_trig_chan: got %h want 1", trig_chan); end
    rd_req = 1'b1; tick();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 4'h0) begin errors++; $display("FAIL len1_read: got v=%0b d=%h want v=1 d=0", rd_valid, rd_data); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL len1_idle: got %0d want 0", state); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rdreq_in_idle: got %0b want 0", rd_valid); end
    rd_req = 1'b0;

    // length 20 behaves as 16
    cfg_write(2'd2, 8'd20);
    in_data = 4'h0;
    settle(2);
    arm = 1'b1; tick(); arm = 1'b0;
    in_data = 4'h1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL clamp_armed: got %0d want 1", state); end
    for (int j = 2; j <= 18; j++) begin
      tick();
      in_data = 4'(j & 15);
      if (j == 3) begin
        checks++; if (state !== 2'd2 || trig_chan !== 4'h1) begin errors++; $display("FAIL clamp_trigger: got st=%0d tc=%h want st=2 tc=1", state, trig_chan); end
      end
      if (j == 17) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL clamp_not_done_early: got %0d want 2", state); end
      end
      if (j == 18) begin
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL clamp_done_at_16: got %0d want 3", state); end
      end
    end
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 4'((i + 1) & 15)) begin errors++; $display("FAIL clamp_read%0d: got v=%0b d=%h want v=1 d=%h", i, rd_valid, rd_data, 4'((i + 1) & 15)); end
      if (i == 14) begin
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL clamp_still_done: got %0d want 3", state); end
      end
    end
    rd_req = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL clamp_idle: got %0d want 0", state); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    cfg_write(2'd2, 8'h00);
    in_data = 4'h0;
    settle(2);
    arm = 1'b1; tick(); arm = 1'b0;
    in_data = 4'h1;
    settle(2);
    checks++; if (state !== 2'd2 || trig_chan !== 4'h1) begin errors++; $display("FAIL rstmid_setup: got st=%0d tc=%h want st=2 tc=1", state, trig_chan); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d want 0", state); end
    checks++; if (trig_chan !== 4'h0 || rd_valid !== 1'b0 || rd_data !== 4'h0) begin errors++; $display("FAIL rstmid_outputs: got tc=%h v=%0b d=%h want all 0", trig_chan, rd_valid, rd_data); end
    in_data = 4'h0;
    tick();
    rst_n = 1'b1;
    settle(2);
    // Mask back to all ones: ch3 alone must trigger
    arm = 1'b1; tick(); arm = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rstmid_rearm: got %0d want 1", state); end
    in_data = 4'h8;
    settle(2);
    checks++; if (state !== 2'd2 || trig_chan !== 4'h8) begin errors++; $display("FAIL rstmid_mask_default: got st=%0d tc=%h want st=2 tc=8", state, trig_chan); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstmid_abort: got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_mask_filter();
    test_prescale_forced();
    test_abort_arb();
    test_boundaries();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
